// File: rtl/sd_bd_fifo.sv
// Two-word buffer-descriptor queue between the SD register slave and the data-transfer master.
// Descriptors are written one word per strobe and read back as a two-cycle acknowledged burst.
module sd_bd_fifo #(
    parameter int BD_SIZE       = 8,
    parameter int RAM_MEM_WIDTH = 32
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     we_m,
    input  logic [RAM_MEM_WIDTH-1:0] dat_in_m,
    input  logic                     re_s,
    output logic [RAM_MEM_WIDTH-1:0] dat_out_s,
    output logic                     ack_o_s,
    output logic [7:0]               free_bd,
    output logic                     bd_empty,
    output logic                     ovf_o
);
    localparam int PW = (BD_SIZE > 1) ? $clog2(BD_SIZE) : 1;
    localparam int AW = PW + 1;
    localparam logic [7:0] CAP = 8'(BD_SIZE);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RD2} state_t;

    logic [RAM_MEM_WIDTH-1:0] mem [0:2*BD_SIZE-1];
    logic [RAM_MEM_WIDTH-1:0] rd_data_q;

    state_t                   state_q, state_d;
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic                     m_phase_q;
    logic [7:0]               count_q, count_d;
    logic                     ovf_q;
    logic                     ack_q, ack_d;
    logic [RAM_MEM_WIDTH-1:0] dat_q, dat_d;

    logic                     full;
    logic                     wr_accept;
    logic                     wr_commit;
    logic                     rd_commit;
    logic [AW-1:0]            rd_addr;
    logic [AW-1:0]            wr_addr;

    // Descriptor being read stays counted until RD2, so writes can never reach its slot.
    assign full      = (count_q == CAP);
    assign wr_accept = we_m & (m_phase_q | ~full);
    assign wr_commit = we_m & m_phase_q;
    assign wr_addr   = {wr_ptr_q, m_phase_q};
    assign count_d   = count_q + 8'(wr_commit) - 8'(rd_commit);

    always_ff @(posedge wb_clk_i) begin
        if (wr_accept) begin
            mem[wr_addr] <= dat_in_m;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q  <= '0;
            m_phase_q <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            ovf_q   <= we_m & ~m_phase_q & full;
            count_q <= count_d;
            if (wr_accept) begin
                m_phase_q <= ~m_phase_q;
            end
            if (wr_commit) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            if (rd_commit) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // The RAM read is one cycle ahead of the output register: word0 is fetched in IDLE, word1 in RD0.
    always_comb begin
        state_d   = state_q;
        rd_addr   = {rd_ptr_q, 1'b0};
        ack_d     = 1'b0;
        dat_d     = dat_q;
        rd_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (re_s && (count_q != 8'd0)) begin
                    state_d = RD0;
                end
            end
            RD0: begin
                rd_addr = {rd_ptr_q, 1'b1};
                ack_d   = 1'b1;
                dat_d   = rd_data_q;
                state_d = RD1;
            end
            RD1: begin
                ack_d   = 1'b1;
                dat_d   = rd_data_q;
                state_d = RD2;
            end
            RD2: begin
                rd_commit = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dat_out_s = dat_q;
    assign ack_o_s   = ack_q;
    assign free_bd   = CAP - count_q;
    assign bd_empty  = (count_q == 8'd0);
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_sd_bd_fifo.sv
// Directed and randomized checks of sd_bd_fifo against a queue-based descriptor model.
module tb_sd_bd_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_m = 1'b0;
    logic [31:0] dat_in_m = '0;
    logic        re_s = 1'b0;
    logic [31:0] dat_out_s;
    logic        ack_o_s;
    logic [7:0]  free_bd;
    logic        bd_empty;
    logic        ovf_o;

    int total = 0;
    int bad   = 0;

    sd_bd_fifo #(.BD_SIZE(8), .RAM_MEM_WIDTH(32)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .we_m     (we_m),
        .dat_in_m (dat_in_m),
        .re_s     (re_s),
        .dat_out_s(dat_out_s),
        .ack_o_s  (ack_o_s),
        .free_bd  (free_bd),
        .bd_empty (bd_empty),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    // Reference model: queued descriptors, pending first word, and cycles since a read was accepted.
    logic [63:0] q[$];
    logic        mph;
    logic [31:0] mw0;
    int          rd_age;
    logic        e_ack;
    logic [31:0] e_dat;
    logic        e_ovf;

    task automatic model_reset();
        q.delete();
        mph    = 1'b0;
        mw0    = '0;
        rd_age = 0;
        e_ack  = 1'b0;
        e_dat  = '0;
        e_ovf  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".free"},  {24'd0, free_bd}, 32'(8 - q.size()));
        chk({tag, ".empty"}, {31'd0, bd_empty}, {31'd0, q.size() == 0});
        chk({tag, ".ack"},   {31'd0, ack_o_s}, {31'd0, e_ack});
        chk({tag, ".dat"},   dat_out_s, e_dat);
        chk({tag, ".ovf"},   {31'd0, ovf_o}, {31'd0, e_ovf});
    endtask

    // One clock: apply inputs, advance the model by the same edge, then compare.
    task automatic cyc(input logic we, input logic [31:0] d, input logic re, input string tag);
        bit full, nonempty;
        we_m = we; dat_in_m = d; re_s = re;
        full     = (q.size() == 8);
        nonempty = (q.size() != 0);
        e_ovf    = 1'b0;
        case (rd_age)
            0: begin e_ack = 1'b0; if (re && nonempty) rd_age = 1; end
            1: begin e_ack = 1'b1; e_dat = q[0][63:32]; rd_age = 2; end
            2: begin e_ack = 1'b1; e_dat = q[0][31:0];  rd_age = 3; end
            default: begin e_ack = 1'b0; void'(q.pop_front()); rd_age = 0; end
        endcase
        if (we) begin
            if (mph) begin
                q.push_back({mw0, d});
                mph = 1'b0;
            end else if (!full) begin
                mw0 = d;
                mph = 1'b1;
            end else begin
                e_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        we_m = 1'b0; re_s = 1'b0;
        chk_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, tag);
    endtask

    task automatic wr_desc(input logic [31:0] w0, input logic [31:0] w1, input string tag);
        cyc(1'b1, w0, 1'b0, tag);
        cyc(1'b1, w1, 1'b0, tag);
    endtask

    task automatic rd_desc(input string tag);
        cyc(1'b0, 32'd0, 1'b1, tag);
        idle(3, tag);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all("reset");

        // Single descriptor round trip.
        wr_desc(32'h0000_0010, 32'h2000_0000, "wr1");
        chk("wr1.free7", {24'd0, free_bd}, 32'd7);
        rd_desc("rd1");
        chk("rd1.free8", {24'd0, free_bd}, 32'd8);

        // Fill, overflow, drain (pointers wrap because they start at 1).
        for (int i = 0; i < 8; i++) wr_desc(32'h1000_0000 + i, 32'hA000_0000 + i, "fill");
        chk("full.free0", {24'd0, free_bd}, 32'd0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, "ovf");
        chk("ovf.pulse", {31'd0, ovf_o}, 32'd1);
        idle(1, "ovf.drop");
        for (int i = 0; i < 8; i++) rd_desc("drain");
        for (int i = 0; i < 4; i++) wr_desc(32'h9000_0000 + i, 32'hC000_0000 + i, "wrap");
        for (int i = 0; i < 4; i++) rd_desc("wrapr");

        // Requests with nothing complete queued.
        rd_desc("rd.empty");
        cyc(1'b1, 32'h5555_0000, 1'b0, "half");
        rd_desc("rd.half");
        chk("half.noack", {31'd0, ack_o_s}, 32'd0);
        cyc(1'b1, 32'h5555_0001, 1'b0, "half.done");
        rd_desc("rd.halfdone");

        // Write completion coincident with read commit at free_bd=3.
        for (int i = 0; i < 5; i++) wr_desc(32'h7000_0000 + i, 32'h7100_0000 + i, "pre3");
        chk("pre3.free", {24'd0, free_bd}, 32'd3);
        cyc(1'b0, 32'd0, 1'b1, "coin.acc");
        cyc(1'b0, 32'd0, 1'b0, "coin.rd0");
        cyc(1'b1, 32'h7700_0000, 1'b0, "coin.rd1");
        cyc(1'b1, 32'h7700_0001, 1'b0, "coin.rd2");
        chk("coin.free3", {24'd0, free_bd}, 32'd3);
        for (int i = 0; i < 5; i++) rd_desc("coin.drain");

        // Reset during RD1 drops the ack immediately.
        wr_desc(32'h3333_0000, 32'h3333_0001, "rstwr");
        cyc(1'b0, 32'd0, 1'b1, "rst.acc");
        cyc(1'b0, 32'd0, 1'b0, "rst.rd0");
        chk("rst.ackhigh", {31'd0, ack_o_s}, 32'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk_all("rst.async");
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all("rst.rel");

        // Extra requests while a read is in progress are ignored.
        wr_desc(32'h4444_0000, 32'h4444_0001, "ign.a");
        wr_desc(32'h4444_0002, 32'h4444_0003, "ign.b");
        cyc(1'b0, 32'd0, 1'b1, "ign.acc");
        cyc(1'b0, 32'd0, 1'b1, "ign.rd0");
        cyc(1'b0, 32'd0, 1'b1, "ign.rd1");
        cyc(1'b0, 32'd0, 1'b0, "ign.rd2");
        idle(2, "ign.idle");
        chk("ign.free7", {24'd0, free_bd}, 32'd7);
        rd_desc("ign.last");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 30), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd_bd_fifo.md
# sd_bd_fifo

Buffer-descriptor queue sitting directly downstream of the SD controller's Wishbone register slave: it captures the two-word descriptors (SD block address, then system memory address) that the register slave streams out on its master-side BD write strobe and data bus. The block hands them in order to the data-transfer master and reports free slots for the BD status register. Two instances are used, one for RX and one for TX.

## Interface
- BD_SIZE, 8, descriptor capacity; power of two, 2..128
- RAM_MEM_WIDTH, 32, descriptor word width; RAM holds 2*BD_SIZE words

- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- we_m  in  1  master-side write strobe, one word per high cycle
- dat_in_m  in  RAM_MEM_WIDTH  word written when we_m high
- re_s  in  1  slave-side single-cycle request for the next descriptor
- dat_out_s  out  RAM_MEM_WIDTH  descriptor word, valid while ack_o_s high
- ack_o_s  out  1  word-valid strobe, high for exactly two consecutive cycles per descriptor
- free_bd  out  8  free descriptor slots, 0..BD_SIZE
- bd_empty  out  1  high when no complete descriptor is queued
- ovf_o  out  1  one-cycle pulse: write attempted with queue full

## Operation
- Storage: 2*BD_SIZE x RAM_MEM_WIDTH RAM, synchronous write and read; word0 at index 2*ptr, word1 at 2*ptr+1.
- Pointers wr_ptr, rd_ptr: log2(BD_SIZE) bits, wrap modulo BD_SIZE. count = BD_SIZE - free_bd, held in an 8-bit register.
- Write side, phase bit m_phase:
  - we_m, m_phase=0, free_bd>0: store word0 at 2*wr_ptr, m_phase<=1.
  - we_m, m_phase=0, free_bd=0: word dropped, ovf_o pulses next cycle, m_phase stays 0.
  - we_m, m_phase=1: store word1 at 2*wr_ptr+1, wr_ptr<=wr_ptr+1, m_phase<=0, free_bd decrements.
  - A half-written descriptor does not count as queued. bd_empty and the read side ignore it.
- Read FSM states: IDLE, RD0, RD1, RD2.
  - IDLE: re_s & ~bd_empty -> RD0, RAM read address 2*rd_ptr. re_s while empty is ignored, no ack.
  - RD0 -> RD1: RAM read address 2*rd_ptr+1. Registered output dat_out_s=word0, ack_o_s=1.
  - RD1 -> RD2: dat_out_s=word1, ack_o_s=1.
  - RD2 -> IDLE: ack_o_s=0, rd_ptr<=rd_ptr+1, free_bd increments.
  - re_s outside IDLE is ignored. Requests are not queued.
- Simultaneous commits: a write completion (word1) and a read commit (RD2) in the same cycle leave free_bd unchanged. Both pointers advance.
- A read in progress always targets a complete descriptor. Writes cannot overwrite it because free_bd excludes that slot until RD2.
- dat_out_s holds its last value when ack_o_s is low.

## Timing
- Reset values: free_bd=BD_SIZE, bd_empty=1, ack_o_s=0, ovf_o=0, dat_out_s=0, wr_ptr=rd_ptr=0, m_phase=0, FSM=IDLE. RAM contents are undefined.
- Reset asserted mid-operation aborts any read and discards partial and queued descriptors.
- Write latency: word1 on cycle N -> free_bd and bd_empty updated at cycle N+1. A re_s on N+1 is accepted.
- Read latency: re_s sampled at edge N -> ack_o_s high with word0 in cycle N+1, with word1 in cycle N+2, low in N+3. free_bd updated at N+3.
- Minimum re_s spacing for back-to-back descriptors: 4 cycles. The next re_s is accepted in the cycle the FSM returns to IDLE.
- ovf_o: cycle after the dropped write, width 1.

## Test plan
- Reset, then write 0x00000010/0x20000000 -> free_bd 8->7, bd_empty 0. Pulse re_s -> ack two cycles with 0x00000010 then 0x20000000, free_bd back to 8.
- Write 8 descriptors, then a 9th word0 -> ovf_o one pulse, free_bd stays 0. Read all 8 -> FIFO order preserved, wrap verified on descriptors 9-12.
- re_s while empty, and re_s with only word0 written -> no ack_o_s, state stays IDLE.
- With free_bd=3, word1 write coincides with RD2 -> free_bd stays 3, pointers both advance.
- Assert wb_rst_i during RD1 -> ack_o_s drops immediately, free_bd=8, bd_empty=1.
- re_s pulses during RD0/RD1 -> ignored, exactly one descriptor consumed.
